// File: rtl/i2s_stereo_if.sv
// Stereo sample stream between the audio DSP pipeline and the I2S transceiver.
// The DSP side uses the master modport; the transceiver uses the slave modport.
interface i2s_stereo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_left;
  logic [DATA_WIDTH-1:0] tx_right;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic [DATA_WIDTH-1:0] rx_left;
  logic [DATA_WIDTH-1:0] rx_right;
  logic                  rx_valid;

  modport master (
    output tx_left, tx_right, tx_valid,
    input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid
  );

  modport slave (
    input  tx_left, tx_right, tx_valid,
    output tx_ready, tx_underrun, rx_left, rx_right, rx_valid
  );
endinterface

// File: rtl/i2s_stereo_transceiver.sv
// Stereo I2S master: derives BCLK/LRCLK from clk, serialises a held stereo sample
// per frame (Philips or left-justified) and captures the codec's stereo sample.
module i2s_stereo_transceiver #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int FORMAT     = 0
) (
  input  logic       clk,
  input  logic       rst,
  i2s_stereo_if.slave bus,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata_out,
  input  logic       i2s_sdata_in
);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] SLOT_POS = PW'(SLOT_WIDTH);

  logic [CW-1:0]         bclk_cnt;
  logic [PW-1:0]         pos;
  logic [PW-1:0]         pos_next;
  logic [PW-1:0]         pos_after;
  logic                  hold_full;
  logic                  hold_full_next;
  logic                  rx_armed;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [FRAME_BITS-1:0] active;
  logic [FRAME_BITS-1:0] active_next;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] rx_shift_next;
  logic                  tick;
  logic                  rise_tick;
  logic                  fall_tick;
  logic                  frame_tick;
  logic                  accept;
  logic                  lrclk_next;

  // Frame vectors hold pos 0 in the MSB, so bit index is always POS_LAST - pos.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DATA_WIDTH-1:0] left,
                                                       input logic [DATA_WIDTH-1:0] right);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: DATA_WIDTH] = left;
    f[SLOT_WIDTH-1 -: DATA_WIDTH] = right;
    return f;
  endfunction

  always_comb begin
    tick       = (bclk_cnt == CNT_LAST);
    rise_tick  = tick && !i2s_bclk;
    fall_tick  = tick && i2s_bclk;
    pos_next   = (pos == POS_LAST) ? '0 : pos + 1'b1;
    pos_after  = (pos_next == POS_LAST) ? '0 : pos_next + 1'b1;
    frame_tick = fall_tick && (pos == POS_LAST);
    accept     = bus.tx_valid && bus.tx_ready;

    // An accept in an underrunning frame-tick cycle wins: the sample waits for the next frame.
    hold_full_next = hold_full;
    if (accept) begin
      hold_full_next = 1'b1;
    end else if (frame_tick) begin
      hold_full_next = 1'b0;
    end

    active_next = active;
    if (frame_tick) begin
      active_next = hold_full ? pack_frame(hold_left, hold_right) : '0;
    end

    if (FORMAT == 1) begin
      lrclk_next = (pos_next < SLOT_POS);
    end else begin
      lrclk_next = (pos_after >= SLOT_POS);
    end

    rx_shift_next = rx_shift;
    if (rise_tick) begin
      rx_shift_next[POS_LAST - pos] = i2s_sdata_in;
    end
  end

  assign bus.tx_underrun = frame_tick && !hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_cnt      <= '0;
      i2s_bclk      <= 1'b0;
      i2s_lrclk     <= 1'b0;
      i2s_sdata_out <= 1'b0;
      pos           <= POS_LAST;
      hold_full     <= 1'b0;
      hold_left     <= '0;
      hold_right    <= '0;
      active        <= '0;
      rx_shift      <= '0;
      rx_armed      <= 1'b0;
      bus.tx_ready  <= 1'b1;
      bus.rx_left   <= '0;
      bus.rx_right  <= '0;
      bus.rx_valid  <= 1'b0;
    end else begin
      bclk_cnt <= tick ? '0 : bclk_cnt + 1'b1;
      if (tick) begin
        i2s_bclk <= !i2s_bclk;
      end
      if (fall_tick) begin
        pos           <= pos_next;
        i2s_lrclk     <= lrclk_next;
        i2s_sdata_out <= active_next[POS_LAST - pos_next];
      end
      if (frame_tick) begin
        rx_armed <= 1'b1;
      end
      hold_full    <= hold_full_next;
      bus.tx_ready <= !hold_full_next;
      if (accept) begin
        hold_left  <= bus.tx_left;
        hold_right <= bus.tx_right;
      end
      active   <= active_next;
      rx_shift <= rx_shift_next;

      // Only frames that started after reset are reported, so a partial frame never publishes.
      bus.rx_valid <= 1'b0;
      if (rise_tick && (pos == POS_LAST) && rx_armed) begin
        bus.rx_valid <= 1'b1;
        bus.rx_left  <= rx_shift_next[FRAME_BITS-1 -: DATA_WIDTH];
        bus.rx_right <= rx_shift_next[SLOT_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_i2s_stereo_transceiver.sv
// Directed bench for i2s_stereo_transceiver: a Philips 16/16 instance and a
// left-justified 12/16 instance, both with serial data looped back, CLK_DIV=2.
module tb_i2s_stereo_transceiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bclk_a, lrclk_a, sdo_a;
  logic bclk_b, lrclk_b, sdo_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rxv_a = 0, rxv_a_last = 0;
  int und_a = 0, und_a_last = 0;
  int acc_a = 0, acc_a_last = 0;
  int ones_a = 0;

  i2s_stereo_if #(.DATA_WIDTH(16)) bus_a ();
  i2s_stereo_if #(.DATA_WIDTH(12)) bus_b ();

  i2s_stereo_transceiver #(.CLK_DIV(2), .DATA_WIDTH(16), .SLOT_WIDTH(16), .FORMAT(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .i2s_bclk(bclk_a), .i2s_lrclk(lrclk_a), .i2s_sdata_out(sdo_a), .i2s_sdata_in(sdo_a)
  );

  i2s_stereo_transceiver #(.CLK_DIV(2), .DATA_WIDTH(12), .SLOT_WIDTH(16), .FORMAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .i2s_bclk(bclk_b), .i2s_lrclk(lrclk_b), .i2s_sdata_out(sdo_b), .i2s_sdata_in(sdo_b)
  );

  always #5 clk = ~clk;

  // Cycle index relative to the last reset, plus event counters sampled on the active edge.
  always @(posedge clk) begin
    cyc <= rst ? 0 : cyc + 1;
    if (bus_a.rx_valid) begin
      rxv_a      <= rxv_a + 1;
      rxv_a_last <= cyc;
    end
    if (bus_a.tx_underrun) begin
      und_a      <= und_a + 1;
      und_a_last <= cyc;
    end
    if (!rst && bus_a.tx_valid && bus_a.tx_ready) begin
      acc_a      <= acc_a + 1;
      acc_a_last <= cyc;
    end
    if (sdo_a) ones_a <= ones_a + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] bclk_seen;
    logic [3:0] lr_seen;
    $display("[TB] test_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk_a, lrclk_a, sdo_a, bus_a.tx_ready, bus_a.tx_underrun, bus_a.rx_valid} !== 6'b000100) begin
      errors++;
      $display("[TB] FAIL reset_in_progress_a: got %b expected 000100",
               {bclk_a, lrclk_a, sdo_a, bus_a.tx_ready, bus_a.tx_underrun, bus_a.rx_valid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus_a.rx_left, bus_a.rx_right} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rx_a: got %h expected 00000000", {bus_a.rx_left, bus_a.rx_right});
    end
    checks++;
    if ({bclk_b, lrclk_b, sdo_b, bus_b.tx_ready, bus_b.tx_underrun, bus_b.rx_valid,
         bus_b.rx_left, bus_b.rx_right} !== {6'b000100, 24'h0}) begin
      errors++;
      $display("[TB] FAIL reset_b: got %h expected %h",
               {bclk_b, lrclk_b, sdo_b, bus_b.tx_ready, bus_b.tx_underrun, bus_b.rx_valid,
                bus_b.rx_left, bus_b.rx_right}, {6'b000100, 24'h0});
    end
    for (int c = 0; c <= 8; c++) begin
      at_cycle(c);
      bclk_seen[c] = bclk_a;
    end
    checks++;
    if (bclk_seen !== 9'b011001100) begin
      errors++;
      $display("[TB] FAIL bclk_start: got %b expected 011001100", bclk_seen);
    end
    at_cycle(63);  lr_seen[3] = lrclk_a;
    at_cycle(64);  lr_seen[2] = lrclk_a;
    at_cycle(191); lr_seen[1] = lrclk_a;
    at_cycle(192); lr_seen[0] = lrclk_a;
    checks++;
    if (lr_seen !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL frame_period: got %b expected 0101", lr_seen);
    end
  endtask

  task automatic test_format0();
    logic [31:0] frame_bits;
    logic        lr_exp;
    int          r0;
    $display("[TB] test_format0");
    frame_bits = {16'hA5C3, 16'h0F01};
    do_reset();
    r0 = rxv_a;
    bus_a.tx_left  = 16'hA5C3;
    bus_a.tx_right = 16'h0F01;
    bus_a.tx_valid = 1'b1;
    at_cycle(1);
    bus_a.tx_valid = 1'b0;
    checks++;
    if (bus_a.tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL f0_ready_drop: got %b expected 0", bus_a.tx_ready);
    end
    at_cycle(4);
    checks++;
    if (bus_a.tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL f0_ready_back: got %b expected 1", bus_a.tx_ready);
    end
    for (int p = 0; p < 32; p++) begin
      at_cycle(6 + 4 * p);
      lr_exp = (((p + 1) % 32) >= 16);
      checks++;
      if (sdo_a !== frame_bits[31 - p]) begin
        errors++;
        $display("[TB] FAIL f0_sdata pos %0d: got %b expected %b", p, sdo_a, frame_bits[31 - p]);
      end
      checks++;
      if (lrclk_a !== lr_exp) begin
        errors++;
        $display("[TB] FAIL f0_lrclk pos %0d: got %b expected %b", p, lrclk_a, lr_exp);
      end
    end
    at_cycle(130);
    checks++;
    if ({bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right} !== {1'b1, 16'hA5C3, 16'h0F01}) begin
      errors++;
      $display("[TB] FAIL f0_rx: got %h expected 1a5c30f01",
               {bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right});
    end
    at_cycle(200);
    checks++;
    if (rxv_a - r0 !== 1 || rxv_a_last !== 130) begin
      errors++;
      $display("[TB] FAIL f0_rx_pulses: got count %0d last %0d expected count 1 last 130",
               rxv_a - r0, rxv_a_last);
    end
  endtask

  task automatic test_format1();
    logic [31:0] frame_bits;
    logic        lr_exp;
    $display("[TB] test_format1");
    frame_bits = 32'hFFF0_8000;
    do_reset();
    bus_b.tx_left  = 12'hFFF;
    bus_b.tx_right = 12'h800;
    bus_b.tx_valid = 1'b1;
    at_cycle(1);
    bus_b.tx_valid = 1'b0;
    at_cycle(3);
    checks++;
    if (lrclk_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL f1_lrclk_pre: got %b expected 0", lrclk_b);
    end
    for (int p = 0; p < 32; p++) begin
      at_cycle(6 + 4 * p);
      lr_exp = (p < 16);
      checks++;
      if (sdo_b !== frame_bits[31 - p]) begin
        errors++;
        $display("[TB] FAIL f1_sdata pos %0d: got %b expected %b", p, sdo_b, frame_bits[31 - p]);
      end
      checks++;
      if (lrclk_b !== lr_exp) begin
        errors++;
        $display("[TB] FAIL f1_lrclk pos %0d: got %b expected %b", p, lrclk_b, lr_exp);
      end
    end
    at_cycle(130);
    checks++;
    if ({bus_b.rx_valid, bus_b.rx_left, bus_b.rx_right} !== {1'b1, 12'hFFF, 12'h800}) begin
      errors++;
      $display("[TB] FAIL f1_rx: got %h expected 1fff800",
               {bus_b.rx_valid, bus_b.rx_left, bus_b.rx_right});
    end
  endtask

  task automatic test_underrun();
    int u0, o0;
    $display("[TB] test_underrun");
    bus_a.tx_valid = 1'b0;
    do_reset();
    u0 = und_a;
    o0 = ones_a;
    at_cycle(300);
    checks++;
    if (und_a - u0 !== 3 || und_a_last !== 259) begin
      errors++;
      $display("[TB] FAIL und_three_frames: got count %0d last %0d expected count 3 last 259",
               und_a - u0, und_a_last);
    end
    checks++;
    if (ones_a - o0 !== 0) begin
      errors++;
      $display("[TB] FAIL und_sdata_quiet: got %0d high cycles expected 0", ones_a - o0);
    end
    at_cycle(387);
    checks++;
    if (bus_a.tx_underrun !== 1'b1 || bus_a.tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL und_tick_state: got underrun %b ready %b expected 1 1",
               bus_a.tx_underrun, bus_a.tx_ready);
    end
    bus_a.tx_left  = 16'hA5C3;
    bus_a.tx_right = 16'h0F01;
    bus_a.tx_valid = 1'b1;
    at_cycle(388);
    bus_a.tx_valid = 1'b0;
    checks++;
    if (bus_a.tx_ready !== 1'b0 || und_a - u0 !== 4 || und_a_last !== 387) begin
      errors++;
      $display("[TB] FAIL und_accept_on_tick: got ready %b count %0d last %0d expected 0 4 387",
               bus_a.tx_ready, und_a - u0, und_a_last);
    end
    at_cycle(390);
    checks++;
    if (sdo_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL und_frame_zero: got %b expected 0", sdo_a);
    end
    at_cycle(515);
    checks++;
    if (bus_a.tx_underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL und_next_frame: got %b expected 0", bus_a.tx_underrun);
    end
    at_cycle(518);
    checks++;
    if (sdo_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL und_late_msb: got %b expected 1", sdo_a);
    end
    at_cycle(522);
    checks++;
    if (sdo_a !== 1'b0 || und_a - u0 !== 4) begin
      errors++;
      $display("[TB] FAIL und_late_bit1: got sdata %b count %0d expected 0 4", sdo_a, und_a - u0);
    end
  endtask

  task automatic test_back_to_back();
    int a0, u0;
    $display("[TB] test_back_to_back");
    bus_a.tx_left  = 16'h1234;
    bus_a.tx_right = 16'h5678;
    bus_a.tx_valid = 1'b1;
    do_reset();
    a0 = acc_a;
    u0 = und_a;
    at_cycle(2);
    checks++;
    if (bus_a.tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_ready_c2: got %b expected 0", bus_a.tx_ready);
    end
    at_cycle(4);
    checks++;
    if (bus_a.tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_c4: got %b expected 1", bus_a.tx_ready);
    end
    at_cycle(5);
    checks++;
    if (bus_a.tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_ready_c5: got %b expected 0", bus_a.tx_ready);
    end
    at_cycle(200);
    checks++;
    if (bus_a.tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_ready_mid: got %b expected 0", bus_a.tx_ready);
    end
    at_cycle(397);
    bus_a.tx_valid = 1'b0;
    checks++;
    if (acc_a - a0 !== 5 || acc_a_last !== 388) begin
      errors++;
      $display("[TB] FAIL bp_accepts: got count %0d last %0d expected count 5 last 388",
               acc_a - a0, acc_a_last);
    end
    checks++;
    if (und_a - u0 !== 0) begin
      errors++;
      $display("[TB] FAIL bp_underrun: got %0d expected 0", und_a - u0);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [8:0] bclk_seen;
    int r0;
    $display("[TB] test_mid_frame_reset");
    do_reset();
    bus_a.tx_left  = 16'hA5C3;
    bus_a.tx_right = 16'h0F01;
    bus_a.tx_valid = 1'b1;
    at_cycle(1);
    bus_a.tx_valid = 1'b0;
    r0 = rxv_a;
    at_cycle(84);
    checks++;
    if (sdo_a !== 1'b1 || lrclk_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pos20: got sdata %b lrclk %b expected 1 1", sdo_a, lrclk_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bclk_a, lrclk_a, sdo_a, bus_a.tx_ready, bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right}
        !== {5'b00010, 32'h0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_values: got %h expected %h",
               {bclk_a, lrclk_a, sdo_a, bus_a.tx_ready, bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right},
               {5'b00010, 32'h0});
    end
    for (int c = 0; c <= 8; c++) begin
      at_cycle(c);
      bclk_seen[c] = bclk_a;
      if (c == 3) begin
        checks++;
        if (bus_a.tx_underrun !== 1'b1) begin
          errors++;
          $display("[TB] FAIL mid_first_tick_underrun: got %b expected 1", bus_a.tx_underrun);
        end
      end
    end
    checks++;
    if (bclk_seen !== 9'b011001100) begin
      errors++;
      $display("[TB] FAIL mid_bclk_restart: got %b expected 011001100", bclk_seen);
    end
    at_cycle(129);
    checks++;
    if (rxv_a - r0 !== 0) begin
      errors++;
      $display("[TB] FAIL mid_no_rx_valid: got %0d pulses expected 0", rxv_a - r0);
    end
    at_cycle(130);
    checks++;
    if ({bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL mid_first_rx: got %h expected 100000000",
               {bus_a.rx_valid, bus_a.rx_left, bus_a.rx_right});
    end
    at_cycle(131);
    checks++;
    if (bus_a.rx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rx_pulse_width: got %b expected 0", bus_a.rx_valid);
    end
  endtask

  initial begin
    bus_a.tx_left  = '0;
    bus_a.tx_right = '0;
    bus_a.tx_valid = 1'b0;
    bus_b.tx_left  = '0;
    bus_b.tx_right = '0;
    bus_b.tx_valid = 1'b0;
    test_reset();
    test_format0();
    test_format1();
    test_underrun();
    test_back_to_back();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
